// File: rtl/router_sync_pkg.sv
// Shared constants and types for the 1x3 router synchronizer.
package router_pkg;
    localparam int NUM_PORTS       = 3;
    localparam int ADDR_W          = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
    localparam int DEFAULT_TIMEOUT = 30;

    typedef logic [NUM_PORTS-1:0] port_vec_t;
endpackage

// File: rtl/router_sync_wdog.sv
// Per-port watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive edges with data present and no read.
module router_sync_wdog #(
    parameter int TIMEOUT = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             soft_q, soft_d;

    always_comb begin
        cnt_d  = '0;
        soft_d = 1'b0;
        if (!vld || rd) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            soft_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            soft_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            soft_q <= soft_d;
        end
    end

    assign soft_reset = soft_q;
endmodule

// File: rtl/router_sync.sv
// Router synchronizer: header address latch, FIFO write steering, full mux,
// valid-out and optional per-port watchdogs (macro ROUTER_SYNC_WATCHDOG_EN).
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  port_vec_t         read_enb,
    input  port_vec_t         empty,
    input  port_vec_t         full,
    output port_vec_t         write_enb,
    output logic              fifo_full,
    output port_vec_t         vld_out,
    output port_vec_t         soft_reset
);
    logic [ADDR_W-1:0] addr_q, addr_d;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("router_sync: TIMEOUT must be in 2..255");
    end

    always_comb begin
        addr_d = addr_q;
        if (detect_add) begin
            addr_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= ADDR_INVALID;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Steering and the full mux use the registered address, so a header
    // latched this cycle only takes effect on the next one.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;

`ifdef ROUTER_SYNC_WATCHDOG_EN
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wdog
        router_sync_wdog #(
            .TIMEOUT(TIMEOUT)
        ) u_wdog (
            .clk       (clk),
            .reset     (reset),
            .vld       (vld_out[i]),
            .rd        (read_enb[i]),
            .soft_reset(soft_reset[i])
        );
    end
`else
    logic unused_read_enb;
    assign unused_read_enb = ^read_enb;
    assign soft_reset      = '0;
`endif
endmodule

// File: tb/tb_router_sync.sv
// Directed self-checking bench for router_sync (TIMEOUT = 30).
module tb_router_sync;
    import router_pkg::*;

`ifdef ROUTER_SYNC_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_enb_reg;
    port_vec_t         read_enb, empty, full;
    port_vec_t         write_enb, vld_out, soft_reset;
    logic              fifo_full;

    int n_checks = 0;
    int n_fail   = 0;

    router_sync #(.TIMEOUT(30)) dut (
        .clk          (clk),
        .reset        (reset),
        .detect_add   (detect_add),
        .data_in      (data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb     (read_enb),
        .empty        (empty),
        .full         (full),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .vld_out      (vld_out),
        .soft_reset   (soft_reset)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] wd(input logic [2:0] v);
        return WD_ON ? v : 3'b000;
    endfunction

    initial begin
        reset = 1'b1; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
        read_enb = 3'b000; empty = 3'b111; full = 3'b000;
        ticks(2);
        reset = 1'b0;
        tick();

        // No header latched yet: address is invalid
        write_enb_reg = 1'b1; full = 3'b111;
        #1;
        chk("rst_write_enb", write_enb, 3'b000);
        chk("rst_fifo_full", {2'b00, fifo_full}, 3'b000);
        chk("rst_soft_reset", soft_reset, 3'b000);
        chk("rst_vld_out", vld_out, 3'b000);

        // Latch address 2 then write
        write_enb_reg = 1'b0; full = 3'b000;
        detect_add = 1'b1; data_in = 2'd2;
        tick();
        detect_add = 1'b0; data_in = 2'd0;
        write_enb_reg = 1'b1; full = 3'b100;
        #1;
        chk("addr2_write_enb", write_enb, 3'b100);
        chk("addr2_full_hi", {2'b00, fifo_full}, 3'b001);
        full = 3'b000;
        #1;
        chk("addr2_full_lo", {2'b00, fifo_full}, 3'b000);
        full = 3'b011;
        #1;
        chk("addr2_other_full", {2'b00, fifo_full}, 3'b000);

        // Same-cycle latch and write: old address steers this cycle
        write_enb_reg = 1'b0; full = 3'b000;
        detect_add = 1'b1; data_in = 2'd0;
        tick();
        data_in = 2'd1; write_enb_reg = 1'b1;
        #1;
        chk("same_cycle_old", write_enb, 3'b001);
        tick();
        detect_add = 1'b0;
        #1;
        chk("same_cycle_new", write_enb, 3'b010);
        full = 3'b010;
        #1;
        chk("addr1_fifo_full", {2'b00, fifo_full}, 3'b001);

        // Invalid address 3
        detect_add = 1'b1; data_in = 2'd3;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
        #1;
        chk("addr3_write_enb", write_enb, 3'b000);
        chk("addr3_fifo_full", {2'b00, fifo_full}, 3'b000);
        write_enb_reg = 1'b0; full = 3'b000;

        // Watchdog on port 1: pulse on the 30th unread edge
        empty = 3'b101; read_enb = 3'b000;
        #1;
        chk("vld_out_port1", vld_out, 3'b010);
        ticks(29);
        chk("wd_edge29", soft_reset, 3'b000);
        tick();
        chk("wd_edge30", soft_reset, wd(3'b010));
        tick();
        chk("wd_edge31", soft_reset, 3'b000);

        // Read at the last count suppresses the pulse and restarts counting
        empty = 3'b111;
        tick();
        empty = 3'b101;
        ticks(29);
        read_enb = 3'b010;
        tick();
        chk("wd_read_suppress", soft_reset, 3'b000);
        read_enb = 3'b000;
        ticks(29);
        chk("wd_restart_29", soft_reset, 3'b000);
        tick();
        chk("wd_restart_30", soft_reset, wd(3'b010));

        // Reset mid-count on all ports
        empty = 3'b111;
        tick();
        empty = 3'b000;
        ticks(14);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("wd_mid_reset", soft_reset, 3'b000);
        write_enb_reg = 1'b1;
        #1;
        chk("mid_reset_addr", write_enb, 3'b000);
        write_enb_reg = 1'b0;
        ticks(29);
        chk("wd_after_rst_29", soft_reset, 3'b000);
        tick();
        chk("wd_after_rst_30", soft_reset, wd(3'b111));
        tick();
        chk("wd_after_rst_31", soft_reset, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/router_sync.md
Name: router_sync

Overview:
- Synchronizer/controller between the router input FSM and the three output FIFOs of the 1x3 router.
- Latches the packet destination address from the header byte and steers the FSM's write strobe to exactly one FIFO.
- Muxes the selected FIFO's full flag back to the FSM and presents per-port valid-out to downstream readers.
- Watchdogs each output: fires a one-cycle soft_reset to any port whose data sits unread for TIMEOUT cycles.

Parameters:
- TIMEOUT, 30, consecutive unread cycles (vld_out[i]=1, read_enb[i]=0) before soft_reset[i] pulses; legal range 2..255.
- CNT_W, $clog2(TIMEOUT), width of each per-port watchdog counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- detect_add  in  1  FSM in DECODE_ADDRESS; latch data_in this edge.
- data_in  in  2  destination address from the header byte (0,1,2 valid; 3 invalid).
- write_enb_reg  in  1  FSM write strobe, to be steered to one FIFO.
- read_enb  in  3  per-port read enable from downstream.
- empty  in  3  per-FIFO empty flags.
- full  in  3  per-FIFO full flags.
- write_enb  out  3  one-hot FIFO write enables.
- fifo_full  out  1  full flag of the addressed FIFO, to the FSM.
- vld_out  out  3  per-port data-available indication.
- soft_reset  out  3  per-port watchdog flush pulse; also feeds the FSM soft_reset input.

Behaviour:
Reset values:
- addr register = 2'b11 (invalid), so write_enb = 3'b000 and fifo_full = 0.
- All watchdog counters = 0; soft_reset = 3'b000.

Address latch:
- At any edge with detect_add=1, addr <= data_in. Otherwise addr holds.
- The latch is independent of write_enb_reg.

Write steering (combinational):
- write_enb[i] = write_enb_reg && (addr == i).
- If addr == 3, write_enb = 000 regardless of write_enb_reg.
- If detect_add and write_enb_reg are both high in the same cycle, steering uses the old addr (the new value is visible the next cycle).

fifo_full (combinational):
- Equals full[addr] for addr 0..2.
- Equals 0 for addr 3.

vld_out (combinational):
- vld_out[i] = ~empty[i]. No latency.

Watchdog, per port i, registered, evaluated in priority order each edge:
1. reset: cnt_i = 0, soft_reset[i] = 0.
2. ~vld_out[i] || read_enb[i]: cnt_i = 0, soft_reset[i] = 0.
3. cnt_i == TIMEOUT-1: cnt_i = 0, soft_reset[i] = 1.
4. Otherwise: cnt_i = cnt_i + 1, soft_reset[i] = 0.

Watchdog timing and boundaries:
- soft_reset[i] rises on the TIMEOUT-th consecutive edge at which vld_out[i]=1 and read_enb[i]=0.
- It is high for exactly one cycle, then counting restarts from 0.
- If the FIFO has not flushed, a further pulse follows TIMEOUT edges later.
- A single read_enb[i] cycle at any count, including TIMEOUT-1, clears the count and suppresses the pulse.
- Ports are fully independent; simultaneous pulses on multiple ports are legal.
- reset asserted mid-count clears the counter with no pulse.
- The counter never exceeds TIMEOUT-1; there is no wrap.

Optional Feature:
- Macro: ROUTER_SYNC_WATCHDOG_EN.
- Defined: watchdog counters instantiated; behaviour as above.
- Undefined: no counters are synthesised, soft_reset is tied to 3'b000, and TIMEOUT/CNT_W are unused.
- Address latch, write steering, fifo_full and vld_out are identical in both builds.

Decomposition:
- Package router_pkg:
  - NUM_PORTS = 3
  - ADDR_W = 2
  - ADDR_INVALID = 2'b11
  - DEFAULT_TIMEOUT = 30
  - typedef port_vec_t (logic [NUM_PORTS-1:0])
- Sub-module router_sync_wdog:
  - Ports: clk, reset, vld, rd, soft_reset.
  - One counter per instance; parameter TIMEOUT.
  - Instantiated NUM_PORTS times inside the ROUTER_SYNC_WATCHDOG_EN guard.
- Steering, mux and address latch remain in the top module.

Test Plan:
- Reset, then write_enb_reg=1 with no header latched -> write_enb=000, fifo_full=0, soft_reset=000.
- detect_add=1, data_in=2; next cycle write_enb_reg=1, full=100 -> write_enb=100, fifo_full=1. Then full=000 -> fifo_full=0.
- detect_add=1 and write_enb_reg=1 in the same cycle, old addr=0, data_in=1 -> write_enb=001 that cycle, 010 the next cycle.
- data_in=3 latched, write_enb_reg=1, full=111 -> write_enb=000, fifo_full=0.
- empty[1]=0, read_enb=000 held (TIMEOUT=30) -> soft_reset=010 for exactly one cycle after the 30th edge. Repeating with read_enb[1]=1 pulsed at edge 29 -> no pulse, count restarts.
- empty=000, read_enb=000, reset asserted at edge 15 -> soft_reset stays 000 until 30 further unread edges after reset deasserts. With the macro undefined, soft_reset stays 000 throughout.
